// File: rtl/imem_loader.sv
// imem_loader: boot-time programmer for the instruction memory's write port (port B).
// Packs a little-endian byte stream into DATA_WIDTH-bit words. Each word is written
// to the next address (starting at 0), read back and compared. The CPU is held in
// reset until the whole program has been loaded and verified.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, num_words      load request pulse and word count (sampled in IDLE/DONE/ERR)
//   byte_in, byte_valid   byte stream input
//   byte_ready            loader accepts a byte this cycle
//   mem_addr, mem_data    port-B address and write data
//   mem_we                port-B write enable
//   mem_q                 port-B registered read data
//   cpu_hold              CPU reset hold (low only in DONE)
//   done, error           load verified / readback mismatch or bad length
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start after reset
// RECV   | collecting bytes of the current word
// WRITE  | driving mem_we for the assembled word
// RD     | same address, write disabled; memory registers ram[addr]
// CMP    | compare mem_q with the assembled word, then advance
// DONE   | all words verified, CPU released
// ERR    | readback mismatch (mem_addr = failing word) or bad length
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NB - 1);
  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_RD,
    S_CMP,
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  // Down-counter of words still to be verified, including the current one.
  logic [ADDR_WIDTH:0]   words_left_q, words_left_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      byte_idx_q   <= '0;
      buf_q        <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      byte_idx_q   <= byte_idx_d;
      buf_q        <= buf_d;
      words_left_q <= words_left_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_idx_d   = byte_idx_q;
    buf_d        = buf_q;
    words_left_d = words_left_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          // Address is cleared on every start so a bad-length error reports 0.
          addr_d     = '0;
          byte_idx_d = '0;
          if (num_words == '0) begin
            state_d = S_DONE;
          end else if (num_words > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            words_left_d = num_words;
            state_d      = S_RECV;
          end
        end
      end

      S_RECV: begin
        if (byte_valid) begin
          for (int k = 0; k < NB; k++) begin
            if (byte_idx_q == IDX_W'(k)) begin
              buf_d[8*k +: 8] = byte_in;
            end
          end
          if (byte_idx_q == LAST_IDX) begin
            state_d = S_WRITE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end

      S_WRITE: state_d = S_RD;

      S_RD: state_d = S_CMP;

      S_CMP: begin
        if (mem_q != buf_q) begin
          state_d = S_ERR;
        end else if (words_left_q == ONE_WORD) begin
          state_d = S_DONE;
        end else begin
          // Never wraps: length was bounded to the memory depth at start.
          addr_d       = addr_q + 1'b1;
          words_left_d = words_left_q - 1'b1;
          byte_idx_d   = '0;
          state_d      = S_RECV;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign byte_ready = (state_q == S_RECV);
  assign mem_we     = (state_q == S_WRITE);
  assign mem_addr   = addr_q;
  assign mem_data   = buf_q;
  assign cpu_hold   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time programmer for the dual-port instruction memory; drives the memory's write port (port B).
- Accepts a little-endian byte stream over a valid/ready handshake and packs it into DATA_WIDTH-bit words.
- Writes each word to consecutive addresses from 0, then reads it back and compares.
- Holds the CPU in reset until the program is loaded and verified.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
- ADDR_WIDTH, 12, word address width; memory depth is 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERR.
- num_words  input  ADDR_WIDTH+1  number of words to load; sampled with start.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_addr  output  ADDR_WIDTH  memory port-B address.
- mem_data  output  DATA_WIDTH  memory port-B write data.
- mem_we  output  1  memory port-B write enable.
- mem_q  input  DATA_WIDTH  memory port-B registered read data.
- cpu_hold  output  1  keeps the CPU in reset while high.
- done  output  1  load completed and verified (level).
- error  output  1  readback mismatch or bad length (level, sticky).

Behaviour:
- Reset (rst_n low at a clk edge) forces state IDLE and the following output values: byte_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, done=0, error=0. All internal counters are cleared.
- Reset mid-load aborts immediately; the memory may be left partially written.
- States are IDLE, RECV, WRITE, RD, CMP, DONE, ERR.
- IDLE:
  - start with num_words==0 goes to DONE.
  - start with num_words>2**ADDR_WIDTH goes to ERR.
  - Otherwise start latches the length, clears the word address and byte index, and goes to RECV.
- RECV:
  - byte_ready=1; a byte is accepted on a cycle where byte_valid && byte_ready.
  - Byte k (k=0..DATA_WIDTH/8-1) lands in bits [8k+7:8k] of the shift buffer.
  - On acceptance of the last byte, go to WRITE.
  - byte_ready is 0 in every other state; stalls via byte_valid=0 are unlimited.
- WRITE (one cycle): mem_we=1, mem_addr=current address, mem_data=assembled word. Next state RD.
- RD (one cycle): mem_we=0 with the same address. The memory registers ram[addr] into mem_q at this edge. Next state CMP.
- CMP (one cycle):
  - If mem_q != assembled word, go to ERR.
  - Else if this was the last word, go to DONE.
  - Else increment the address, clear the byte index, and go to RECV.
- Per-word cost is 4 accepted bytes plus 3 cycles (WRITE, RD, CMP) when DATA_WIDTH=32.
- Address arithmetic is unsigned ADDR_WIDTH bits. A full-depth load ends at address 2**ADDR_WIDTH-1 and never wraps, because the length check precedes it.
- DONE: done=1, cpu_hold=0, error=0.
- ERR: error=1, cpu_hold=1, done=0. mem_addr holds the failing address (0 for a bad-length error).
- A start pulse in DONE or ERR begins a new load: done and error drop to 0 and cpu_hold rises to 1 on the next cycle. A start pulse in any other state is ignored.
- cpu_hold is 1 in every state except DONE.
- mem_we is asserted only in WRITE, and exactly once per word.

Test Plan:
- Reset, then num_words=2, stream bytes 78 56 34 12 EF BE AD DE with byte_valid held high -> mem_we pulses at addr 0 with 0x12345678 and at addr 1 with 0xDEADBEEF; done=1, cpu_hold=0; 14 cycles from the first accepted byte to done.
- Same stream with byte_valid toggled 1/0 on alternate cycles -> identical memory contents, byte_ready never high outside RECV, no byte lost or duplicated.
- Memory model corrupts bit 0 on readback of addr 1 -> error=1, mem_addr=1, cpu_hold=1, done=0; a new start then reloads and reaches done.
- num_words=0 -> done=1 the cycle after start, mem_we never asserted. num_words=4097 with ADDR_WIDTH=12 -> error=1, mem_we never asserted.
- Pull rst_n low after 2 words of a 4-word load -> all outputs return to reset values next cycle and the state is IDLE; start ignored while rst_n is low.
- Full-depth load (ADDR_WIDTH=4, num_words=16) -> last write at addr 15, done=1, no write to addr 0 after the first.
